// File: rtl/mr_pkg.sv
// Shared load/store types: memory op / size encodings, LDST FSM states and
// the alignment rule used to decide whether an access can go to the bus.
package mr_pkg;
  localparam int XLEN        = 32;
  localparam int REGSEL_BITS = 5;

  typedef enum logic [1:0] {MEMOP_NONE, MEMOP_LOAD, MEMOP_STORE} e_memops;
  typedef enum logic [1:0] {MEMSZ_B, MEMSZ_H, MEMSZ_W} e_memsz;
  typedef enum logic {LS_IDLE, LS_BUS} e_ls_state;

  function automatic logic misaligned(e_memsz sz, logic [1:0] lo);
    case (sz)
      MEMSZ_H: return lo[0];
      MEMSZ_W: return |lo;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mr_ldst_if.sv
// Word-wide memory bus between the load/store stage (master) and memory (slave).
interface mr_ldst_if;
  import mr_pkg::*;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mr_ldst_align.sv
// Combinational lane steering: store data replication + byte strobes, and
// load byte/half extraction with sign or zero extension.
module mr_ldst_align
  import mr_pkg::*;
(
  input  e_memsz          size,
  input  logic [1:0]      addr_lo,
  input  logic            sgn,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_val
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    wdata    = sdata;
    wstrb    = 4'b1111;
    load_val = rdata;
    b        = rdata[{addr_lo, 3'b000} +: 8];
    h        = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      MEMSZ_B: begin
        wdata    = {4{sdata[7:0]}};
        wstrb    = 4'b0001 << addr_lo;
        load_val = {{(XLEN-8){sgn & b[7]}}, b};
      end
      MEMSZ_H: begin
        wdata    = {2{sdata[15:0]}};
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_val = {{(XLEN-16){sgn & h[15]}}, h};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mr_ldst.sv
// Load/store stage: one instruction in flight, one bus transaction per mem op,
// single-entry writeback slot, fault pulse on misalignment or bus timeout.
module mr_ldst
  import mr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ls_valid,
  output logic                   ls_ready,
  input  logic [XLEN-1:0]        ls_dest,
  input  logic [REGSEL_BITS-1:0] ls_dest_reg,
  input  e_memops                ls_memop,
  input  e_memsz                 ls_size,
  input  logic                   ls_signed,
  input  logic [XLEN-1:0]        ls_payload,
  mr_ldst_if.master              mem,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [REGSEL_BITS-1:0] wb_dest_reg,
  output logic [XLEN-1:0]        wb_value,
  output logic                   ls_fault,
  output logic [XLEN-1:0]        ls_fault_addr
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  e_ls_state              state_q, state_d;
  logic                   op_we, op_signed;
  e_memsz                 op_size;
  logic [XLEN-1:0]        op_addr, op_data;
  logic [REGSEL_BITS-1:0] op_dest_reg;
  logic [CW-1:0]          tmo_cnt;
  logic [XLEN-1:0]        load_val;

  logic xfer, mem_op, misal, ack_hit, timeout_hit;
  logic wb_load, fault_set;
  logic [REGSEL_BITS-1:0] wb_reg_d;
  logic [XLEN-1:0]        wb_val_d, fault_addr_d;

  assign ls_ready    = ~rst & (state_q == LS_IDLE) & (~wb_valid | wb_ready);
  assign xfer        = ls_valid & ls_ready;
  assign mem_op      = ls_memop != MEMOP_NONE;
  assign misal       = misaligned(ls_size, ls_dest[1:0]);
  assign ack_hit     = (state_q == LS_BUS) & mem.mem_ack;
  // A zero limit disables the timeout so the stage waits on the bus forever.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == LS_BUS) && !mem.mem_ack &&
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign mem.mem_req   = state_q == LS_BUS;
  assign mem.mem_we    = op_we;
  assign mem.mem_addr  = {op_addr[XLEN-1:2], 2'b00};

  mr_ldst_align u_align (
    .size    (op_size),
    .addr_lo (op_addr[1:0]),
    .sgn     (op_signed),
    .sdata   (op_data),
    .rdata   (mem.mem_rdata),
    .wdata   (mem.mem_wdata),
    .wstrb   (mem.mem_wstrb),
    .load_val(load_val)
  );

  always_comb begin
    state_d      = state_q;
    wb_load      = 1'b0;
    wb_reg_d     = ls_dest_reg;
    wb_val_d     = ls_dest;
    fault_set    = 1'b0;
    fault_addr_d = ls_dest;
    case (state_q)
      LS_IDLE: if (xfer) begin
        if (!mem_op) begin
          wb_load = ls_dest_reg != '0;
        end else if (misal) begin
          fault_set = 1'b1;
        end else begin
          state_d = LS_BUS;
        end
      end
      LS_BUS: begin
        wb_reg_d     = op_dest_reg;
        wb_val_d     = load_val;
        fault_addr_d = op_addr;
        if (ack_hit) begin
          state_d = LS_IDLE;
          wb_load = !op_we && (op_dest_reg != '0);
        end else if (timeout_hit) begin
          state_d   = LS_IDLE;
          fault_set = 1'b1;
        end
      end
      default: state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LS_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || state_d != LS_BUS) tmo_cnt <= '0;
    else if (TIMEOUT_CYCLES != 0 && state_q == LS_BUS) tmo_cnt <= tmo_cnt + CW'(1);
  end

  // Operand capture happens only on the accept edge; upstream may change after.
  always_ff @(posedge clk) begin
    if (xfer && mem_op) begin
      op_we       <= ls_memop == MEMOP_STORE;
      op_size     <= ls_size;
      op_signed   <= ls_signed;
      op_addr     <= ls_dest;
      op_data     <= ls_payload;
      op_dest_reg <= ls_dest_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_dest_reg   <= '0;
      wb_value      <= '0;
      ls_fault      <= 1'b0;
      ls_fault_addr <= '0;
    end else begin
      if (wb_load) begin
        wb_valid    <= 1'b1;
        wb_dest_reg <= wb_reg_d;
        wb_value    <= wb_val_d;
      end else if (wb_ready) begin
        wb_valid    <= 1'b0;
      end
      ls_fault <= fault_set;
      if (fault_set) ls_fault_addr <= fault_addr_d;
    end
  end
endmodule

// File: tb/tb_mr_ldst.sv
// Directed bench for mr_ldst: table of single-op vectors plus hand sequences
// for back-to-back, slow ack, timeout, writeback stall and mid-op reset.
module tb_mr_ldst;
  import mr_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ls_valid, ls_ready, ls_signed, wb_valid, wb_ready, ls_fault;
  logic [XLEN-1:0]        ls_dest, ls_payload, wb_value, ls_fault_addr;
  logic [REGSEL_BITS-1:0] ls_dest_reg, wb_dest_reg;
  e_memops                ls_memop;
  e_memsz                 ls_size;

  mr_ldst_if mif();

  mr_ldst #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_dest(ls_dest),
    .ls_dest_reg(ls_dest_reg), .ls_memop(ls_memop), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_payload(ls_payload), .mem(mif), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_reg(wb_dest_reg), .wb_value(wb_value), .ls_fault(ls_fault),
    .ls_fault_addr(ls_fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    e_memops     op;
    e_memsz      sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_fault;
    logic        exp_wb;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [17];
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic offer(input e_memops op, input e_memsz sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    ls_valid = 1'b1; ls_memop = op; ls_size = sz; ls_signed = sgn;
    ls_dest = addr; ls_payload = data; ls_dest_reg = rd;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    wb_ready = 1'b1;
    chk({t, "_ready"}, ls_ready, 1);
    offer(v.op, v.sz, v.sgn, v.addr, v.data, v.rd);
    step();
    ls_valid = 1'b0;
    if (v.exp_fault) begin
      chk({t, "_fault"}, ls_fault, 1);
      chk({t, "_fault_addr"}, ls_fault_addr, v.addr);
      chk({t, "_no_req"}, mif.mem_req, 0);
      chk({t, "_no_wb"}, wb_valid, 0);
      step();
      chk({t, "_fault_pulse"}, ls_fault, 0);
    end else if (v.op == MEMOP_NONE) begin
      chk({t, "_wb_valid"}, wb_valid, v.exp_wb);
      if (v.exp_wb) begin
        chk({t, "_wb_reg"}, wb_dest_reg, v.rd);
        chk({t, "_wb_val"}, wb_value, v.exp_val);
      end
      step();
    end else begin
      chk({t, "_req"}, mif.mem_req, 1);
      chk({t, "_addr"}, mif.mem_addr, {v.addr[31:2], 2'b00});
      chk({t, "_we"}, mif.mem_we, v.op == MEMOP_STORE);
      if (v.op == MEMOP_STORE) begin
        chk({t, "_wdata"}, mif.mem_wdata, v.exp_wdata);
        chk({t, "_wstrb"}, mif.mem_wstrb, v.exp_strb);
      end
      mif.mem_ack = 1'b1; mif.mem_rdata = v.rdata;
      step();
      mif.mem_ack = 1'b0;
      chk({t, "_req_drop"}, mif.mem_req, 0);
      chk({t, "_wb_valid"}, wb_valid, v.exp_wb);
      if (v.exp_wb) begin
        chk({t, "_wb_reg"}, wb_dest_reg, v.rd);
        chk({t, "_wb_val"}, wb_value, v.exp_val);
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  reqc;
    bit  done;
    vecs[0]  = '{MEMOP_NONE,  MEMSZ_W, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h1234};
    vecs[1]  = '{MEMOP_NONE,  MEMSZ_W, 1'b0, 32'h5555, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[2]  = '{MEMOP_LOAD,  MEMSZ_B, 1'b1, 32'h103, 32'h0, 5'd1, 32'h80FF_0000, 1'b0, 1'b1, 4'h0, 32'h0, 32'hFFFF_FF80};
    vecs[3]  = '{MEMOP_LOAD,  MEMSZ_B, 1'b0, 32'h101, 32'h0, 5'd2, 32'h1234_5678, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_0056};
    vecs[4]  = '{MEMOP_LOAD,  MEMSZ_H, 1'b1, 32'h002, 32'h0, 5'd3, 32'h8001_7FFF, 1'b0, 1'b1, 4'h0, 32'h0, 32'hFFFF_8001};
    vecs[5]  = '{MEMOP_LOAD,  MEMSZ_H, 1'b0, 32'h000, 32'h0, 5'd4, 32'h8001_F00D, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_F00D};
    vecs[6]  = '{MEMOP_LOAD,  MEMSZ_W, 1'b0, 32'h104, 32'h0, 5'd6, 32'hCAFE_BABE, 1'b0, 1'b1, 4'h0, 32'h0, 32'hCAFE_BABE};
    vecs[7]  = '{MEMOP_LOAD,  MEMSZ_B, 1'b1, 32'h100, 32'h0, 5'd0, 32'h0000_00FF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[8]  = '{MEMOP_STORE, MEMSZ_B, 1'b0, 32'h301, 32'h1234_56A5, 5'd9, 32'h0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{MEMOP_STORE, MEMSZ_B, 1'b0, 32'h003, 32'h0000_007E, 5'd0, 32'h0, 1'b0, 1'b0, 4'b1000, 32'h7E7E_7E7E, 32'h0};
    vecs[10] = '{MEMOP_STORE, MEMSZ_H, 1'b0, 32'h202, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[11] = '{MEMOP_STORE, MEMSZ_H, 1'b0, 32'h1000, 32'h0000_1357, 5'd0, 32'h0, 1'b0, 1'b0, 4'b0011, 32'h1357_1357, 32'h0};
    vecs[12] = '{MEMOP_STORE, MEMSZ_W, 1'b0, 32'h400, 32'h0BAD_F00D, 5'd0, 32'h0, 1'b0, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0};
    vecs[13] = '{MEMOP_LOAD,  MEMSZ_W, 1'b0, 32'h101, 32'h0, 5'd7, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[14] = '{MEMOP_STORE, MEMSZ_H, 1'b0, 32'h203, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[15] = '{MEMOP_LOAD,  MEMSZ_H, 1'b1, 32'h001, 32'h0, 5'd5, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[16] = '{MEMOP_LOAD,  MEMSZ_B, 1'b1, 32'h102, 32'h0, 5'd8, 32'h007F_0000, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_007F};

    rst = 1'b1; ls_valid = 1'b0; ls_memop = MEMOP_NONE; ls_size = MEMSZ_W; ls_signed = 1'b0;
    ls_dest = '0; ls_payload = '0; ls_dest_reg = '0; wb_ready = 1'b1;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    step(); step();
    chk("rst_ready", ls_ready, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fault", ls_fault, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", ls_ready, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // three ALU ops back to back, one per cycle
    offer(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h1234, 32'h0, 5'd5);
    step();
    chk("b2b_ready1", ls_ready, 1);
    chk("b2b_reg1", wb_dest_reg, 5);
    chk("b2b_val1", wb_value, 32'h1234);
    offer(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h2222, 32'h0, 5'd6);
    step();
    chk("b2b_ready2", ls_ready, 1);
    chk("b2b_valid2", wb_valid, 1);
    chk("b2b_val2", wb_value, 32'h2222);
    offer(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h3333, 32'h0, 5'd7);
    step();
    ls_valid = 1'b0;
    chk("b2b_reg3", wb_dest_reg, 7);
    chk("b2b_val3", wb_value, 32'h3333);
    step();
    chk("b2b_drain", wb_valid, 0);

    // LB with ack two cycles after request
    offer(MEMOP_LOAD, MEMSZ_B, 1'b1, 32'h103, 32'h0, 5'd8);
    step();
    ls_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("slow_req%0d", k), mif.mem_req, 1);
      chk($sformatf("slow_addr%0d", k), mif.mem_addr, 32'h100);
      chk($sformatf("slow_ready%0d", k), ls_ready, 0);
      step();
    end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80FF_0000;
    step();
    mif.mem_ack = 1'b0;
    chk("slow_wb_valid", wb_valid, 1);
    chk("slow_wb_val", wb_value, 32'hFFFF_FF80);
    step();

    // bus timeout: request held exactly 4 cycles, then fault
    offer(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h500, 32'h0, 5'd7);
    step();
    ls_valid = 1'b0;
    reqc = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (mif.mem_req) begin reqc++; step(); end
      else done = 1;
    end
    chk("to_req_cycles", reqc, 4);
    chk("to_fault", ls_fault, 1);
    chk("to_fault_addr", ls_fault_addr, 32'h500);
    chk("to_no_wb", wb_valid, 0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_FFFF;
    step();
    mif.mem_ack = 1'b0;
    chk("late_ack_fault", ls_fault, 0);
    chk("late_ack_wb", wb_valid, 0);
    chk("late_ack_ready", ls_ready, 1);
    offer(MEMOP_NONE, MEMSZ_W, 1'b0, 32'hABC, 32'h0, 5'd2);
    step();
    ls_valid = 1'b0;
    chk("after_to_wb", wb_valid, 1);
    chk("after_to_val", wb_value, 32'hABC);
    step();

    // LHU with writeback stalled; a queued ALU op must wait for the slot
    wb_ready = 1'b0;
    offer(MEMOP_LOAD, MEMSZ_H, 1'b0, 32'h002, 32'h0, 5'd10);
    step();
    ls_valid = 1'b0;
    chk("stall_req", mif.mem_req, 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hF00D_0000;
    step();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    offer(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h77, 32'h0, 5'd11);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_valid%0d", k), wb_valid, 1);
      chk($sformatf("stall_val%0d", k), wb_value, 32'h0000_F00D);
      chk($sformatf("stall_reg%0d", k), wb_dest_reg, 10);
      chk($sformatf("stall_ready%0d", k), ls_ready, 0);
      step();
    end
    wb_ready = 1'b1;
    #1;
    chk("stall_release_ready", ls_ready, 1);
    step();
    ls_valid = 1'b0;
    chk("stall_next_val", wb_value, 32'h77);
    chk("stall_next_reg", wb_dest_reg, 11);
    step();
    chk("stall_drain", wb_valid, 0);

    // reset while a load is on the bus
    offer(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h600, 32'h0, 5'd3);
    step();
    ls_valid = 1'b0;
    chk("mid_rst_req", mif.mem_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ls_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_req_drop", mif.mem_req, 0);
    chk("mid_rst_fault", ls_fault, 0);
    chk("mid_rst_ready_back", ls_ready, 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111_1111;
    step();
    mif.mem_ack = 1'b0;
    chk("mid_rst_late_wb", wb_valid, 0);
    chk("mid_rst_late_fault", ls_fault, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
